// File: rtl/bpsk_burst_ctrl.sv
// Burst sequencer for the BPSK sine transmit path: guard, preamble, MSB-first
// payload, guard, then a one-clock done pulse. Drives NCO, polarity and DAC enables.
module bpsk_burst_ctrl #(
  parameter int                  BIT_CYCLES   = 50,
  parameter int                  PRE_BITS     = 16,
  parameter logic [PRE_BITS-1:0] PRE_PATTERN  = 16'hAAAA,
  parameter int                  DATA_W       = 32,
  parameter int                  GUARD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              nco_en,
  output logic              nco_clr,
  output logic              bpsk_bit,
  output logic              bit_strobe,
  output logic              dac_wrt_en,
  output logic              busy,
  output logic              done
);

  localparam int CYC_MAX = (BIT_CYCLES > GUARD_CYCLES) ? BIT_CYCLES : GUARD_CYCLES;
  localparam int CYC_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int BIT_MAX = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
  localparam int BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;
  localparam int SR_W    = PRE_BITS + DATA_W;

  localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] GUARD_LAST = CYC_W'(GUARD_CYCLES - 1);
  localparam logic [BIT_W-1:0] PRE_LAST   = BIT_W'(PRE_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_GUARD_PRE, S_PREAMBLE, S_DATA, S_GUARD_POST, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic              trig_d_q;
  logic              trig_rise;

  logic data_ready_q, data_ready_d;
  logic nco_en_q, nco_en_d;
  logic nco_clr_q, nco_clr_d;
  logic bpsk_bit_q, bpsk_bit_d;
  logic bit_strobe_q, bit_strobe_d;
  logic dac_wrt_en_q, dac_wrt_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  assign trig_rise = trig & ~trig_d_q;

  // Preamble and payload share one shift register, so the symbol is always its MSB.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    sr_d    = sr_q;

    unique case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (trig_rise) state_d = S_ARM;
      end
      S_ARM: begin
        if (data_valid && data_ready_q) begin
          sr_d    = {PRE_PATTERN, data_in};
          cyc_d   = '0;
          state_d = S_GUARD_PRE;
        end
      end
      S_GUARD_PRE: begin
        if (cyc_q == GUARD_LAST) begin
          cyc_d   = '0;
          bit_d   = '0;
          state_d = S_PREAMBLE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_PREAMBLE: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          sr_d  = {sr_q[SR_W-2:0], 1'b0};
          if (bit_q == PRE_LAST) begin
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          sr_d  = {sr_q[SR_W-2:0], 1'b0};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = S_GUARD_POST;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_GUARD_POST: begin
        if (cyc_q == GUARD_LAST) begin
          cyc_d   = '0;
          state_d = S_DONE;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cyc_d   = '0;
      bit_d   = '0;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up with state_q.
  always_comb begin
    data_ready_d = (state_d == S_ARM);
    nco_en_d     = (state_d == S_GUARD_PRE) || (state_d == S_PREAMBLE) ||
                   (state_d == S_DATA) || (state_d == S_GUARD_POST);
    dac_wrt_en_d = nco_en_d;
    nco_clr_d    = (state_d == S_GUARD_PRE) && (cyc_d == '0);
    bit_strobe_d = ((state_d == S_PREAMBLE) || (state_d == S_DATA)) && (cyc_d == '0);
    bpsk_bit_d   = ((state_d == S_PREAMBLE) || (state_d == S_DATA)) && sr_d[SR_W-1];
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      trig_d_q     <= 1'b0;
      data_ready_q <= 1'b0;
      nco_en_q     <= 1'b0;
      nco_clr_q    <= 1'b0;
      bpsk_bit_q   <= 1'b0;
      bit_strobe_q <= 1'b0;
      dac_wrt_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      trig_d_q     <= trig;
      data_ready_q <= data_ready_d;
      nco_en_q     <= nco_en_d;
      nco_clr_q    <= nco_clr_d;
      bpsk_bit_q   <= bpsk_bit_d;
      bit_strobe_q <= bit_strobe_d;
      dac_wrt_en_q <= dac_wrt_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign data_ready = data_ready_q;
  assign nco_en     = nco_en_q;
  assign nco_clr    = nco_clr_q;
  assign bpsk_bit   = bpsk_bit_q;
  assign bit_strobe = bit_strobe_q;
  assign dac_wrt_en = dac_wrt_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bpsk_burst_ctrl.sv
// Self-checking bench for bpsk_burst_ctrl: a table-driven nominal burst, randomized
// bursts against a timeline model, and hand sequences for abort, reset and trig corners.
module tb_bpsk_burst_ctrl;

  localparam int BC = 4;
  localparam int PB = 4;
  localparam int DW = 8;
  localparam int G  = 2;
  localparam logic [PB-1:0] PAT = 4'b1010;
  localparam int ACTIVE = 2 * G + (PB + DW) * BC;  // 52

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          trig = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready, nco_en, nco_clr, bpsk_bit, bit_strobe, dac_wrt_en, busy, done;

  int passed = 0;
  int total  = 0;

  bpsk_burst_ctrl #(
    .BIT_CYCLES(BC), .PRE_BITS(PB), .PRE_PATTERN(PAT), .DATA_W(DW), .GUARD_CYCLES(G)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .abort(abort), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .nco_en(nco_en), .nco_clr(nco_clr),
    .bpsk_bit(bpsk_bit), .bit_strobe(bit_strobe), .dac_wrt_en(dac_wrt_en), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // Output bundle order: {data_ready, nco_en, nco_clr, bpsk_bit, bit_strobe, dac_wrt_en, busy, done}
  localparam logic [7:0] EXP_IDLE = 8'b0000_0000;
  localparam logic [7:0] EXP_ARM  = 8'b1000_0010;
  localparam logic [7:0] EXP_DONE = 8'b0000_0011;

  function automatic logic [7:0] outs();
    return {data_ready, nco_en, nco_clr, bpsk_bit, bit_strobe, dac_wrt_en, busy, done};
  endfunction

  // Expected outputs t clocks after the transfer edge, straight from the burst timeline.
  function automatic logic [7:0] model(input logic [DW-1:0] d, input int t);
    logic [PB-1:0] pat;
    int   k;
    logic b, stb;
    pat = PAT;
    if (t < G) return {1'b0, 1'b1, (t == 0), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    if (t < G + (PB + DW) * BC) begin
      k   = (t - G) / BC;
      stb = ((t - G) % BC) == 0;
      b   = (k < PB) ? pat[PB-1-k] : d[DW-1-(k-PB)];
      return {1'b0, 1'b1, 1'b0, b, stb, 1'b1, 1'b1, 1'b0};
    end
    if (t < ACTIVE) return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    if (t == ACTIVE) return EXP_DONE;
    return EXP_IDLE;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One burst: trig edge, `delay` idle ARM cycles, transfer, then the full timeline.
  // cut_kind: 0 = none, 1 = abort at clock cut_t, 2 = async reset before clock cut_t.
  task automatic run_burst(input logic [DW-1:0] d, input int delay, input bit retrig,
                           input bit hold, input int cut_kind, input int cut_t);
    int dr_cnt, done_cnt;
    dr_cnt = 0;
    done_cnt = 0;
    trig = 1'b1;
    data_valid = 1'b0;
    tick();
    check("arm_entry", outs(), EXP_ARM);
    if (!hold) trig = 1'b0;
    if (data_ready) dr_cnt++;
    for (int i = 0; i < delay; i++) begin
      data_in = DW'($urandom);
      tick();
      check("arm_wait", outs(), EXP_ARM);
      if (data_ready) dr_cnt++;
    end
    for (int t = 0; t <= ACTIVE + 1; t++) begin
      if (cut_kind == 2 && t == cut_t) begin
        rst_n = 1'b0;
        #2;
        check("async_reset_outs", outs(), EXP_IDLE);
        #1;
        rst_n = 1'b1;
        trig = 1'b0;
        for (int i = 0; i < 4; i++) begin
          tick();
          check("post_reset_idle", outs(), EXP_IDLE);
        end
        return;
      end
      data_valid = (t == 0) ? 1'b1 : 1'($urandom);
      data_in    = (t == 0) ? d : DW'($urandom);
      if (!hold) trig = (retrig && t >= 2 && t <= ACTIVE - 2) ? 1'($urandom) : 1'b0;
      abort = (cut_kind == 1 && t == cut_t);
      tick();
      abort = 1'b0;
      if (cut_kind == 1 && t == cut_t) begin
        check("abort_outs", outs(), EXP_IDLE);
        data_valid = 1'b0;
        tick();
        check("abort_stay_idle", outs(), EXP_IDLE);
        return;
      end
      check($sformatf("burst_t%0d", t), outs(), model(d, t));
      if (data_ready) dr_cnt++;
      if (done) done_cnt++;
    end
    data_valid = 1'b0;
    if (!hold) trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after_idle", outs(), EXP_IDLE);
      if (done) done_cnt++;
    end
    check("ready_cycles", dr_cnt, delay + 1);
    check("done_count", done_cnt, 1);
  endtask

  typedef struct {
    logic          trig;
    logic          valid;
    logic [DW-1:0] din;
    logic [7:0]    exp;
  } vec_t;

  vec_t vecs[ACTIVE + 3];

  initial begin
    // Nominal table: edge, immediate transfer of 8'hC3, whole timeline, back to idle.
    vecs[0] = '{trig: 1'b1, valid: 1'b0, din: 8'h00, exp: EXP_ARM};
    vecs[1] = '{trig: 1'b0, valid: 1'b1, din: 8'hC3, exp: model(8'hC3, 0)};
    for (int t = 1; t <= ACTIVE + 1; t++)
      vecs[t + 1] = '{trig: 1'b0, valid: 1'b0, din: 8'h00, exp: model(8'hC3, t)};

    #3;
    check("reset_outs", outs(), EXP_IDLE);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_after_release", outs(), EXP_IDLE);

    // Test 1: nominal burst from the vector table.
    for (int i = 0; i < ACTIVE + 3; i++) begin
      trig = vecs[i].trig;
      data_valid = vecs[i].valid;
      data_in = vecs[i].din;
      tick();
      check($sformatf("nominal_v%0d", i), outs(), vecs[i].exp);
    end
    tick();

    // Test 2: late data, 19 wait cycles -> 20 ready cycles.
    run_burst(8'h5A, 19, 1'b0, 1'b0, 0, 0);

    // Test 3: retriggers during the burst are ignored.
    run_burst(8'h96, 0, 1'b1, 1'b0, 0, 0);

    // Test 4: abort after 3 data bits, then a clean burst.
    run_burst(8'hF0, 1, 1'b0, 1'b0, 1, G + (PB + 3) * BC);
    run_burst(8'h3C, 0, 1'b0, 1'b0, 0, 0);

    // Abort together with a transfer discards the word.
    trig = 1'b1;
    tick();
    check("arm_before_abort", outs(), EXP_ARM);
    trig = 1'b0;
    data_valid = 1'b1;
    data_in = 8'hFF;
    abort = 1'b1;
    tick();
    check("abort_beats_transfer", outs(), EXP_IDLE);
    abort = 1'b0;
    data_valid = 1'b0;
    tick();
    check("abort_transfer_idle", outs(), EXP_IDLE);

    // Abort in IDLE does not block a start.
    abort = 1'b1;
    trig = 1'b1;
    tick();
    check("abort_in_idle_ignored", outs(), EXP_ARM);
    abort = 1'b0;
    trig = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h81;
    for (int t = 0; t <= ACTIVE; t++) begin
      tick();
      data_valid = 1'b0;
      check($sformatf("abort_idle_burst_t%0d", t), outs(), model(8'h81, t));
    end
    tick();

    // Test 5: async reset mid-preamble, then stay idle.
    run_burst(8'hA5, 2, 1'b0, 1'b0, 2, G + 5);

    // Randomized bursts against the timeline model.
    for (int r = 0; r < 6; r++)
      run_burst(DW'($urandom), int'($urandom_range(0, 6)), 1'($urandom), 1'b0, 0, 0);

    // Test 6: trig tied high from reset release -> exactly one burst.
    trig = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    run_burst(8'h6E, 0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("trig_held_no_second", outs(), EXP_IDLE);
    end
    trig = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
